master_port: RTL and testbench
==============================

# master_port

Master-side serializer that drives the serial bus slave. Accepts parallel read/write requests (single or burst) from the bus master logic and emits the slave's serial protocol: valid/wren/burst header, 12 address bits, then 8-bit data beats. On reads, it deserializes returned bytes. It sits directly upstream of the slave port and is its only driver.

## Interface
- ADDR_W, 12, address width, shifted LSB first
- DATA_W, 8, beat width, shifted LSB first
- BURST_LEN, 128, beats per burst transaction
- TIMEOUT, 1024, watchdog limit in cycles (used only with MASTER_PORT_TIMEOUT_EN)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready
- req_wren  in  1  1 = write, 0 = read
- req_burst  in  1  1 = BURST_LEN beats, 0 = single beat
- req_addr  in  ADDR_W  start address
- wdata_valid  in  1  write byte present
- wdata_ready  out  1  high in WLOAD
- wdata  in  DATA_W  write byte
- rdata_valid  out  1  one-cycle pulse per received byte
- rdata  out  DATA_W  received byte, held until next pulse
- done  out  1  one-cycle pulse at transaction end
- err  out  1  one-cycle pulse on watchdog abort (always 0 without macro)
- validIn  out  1  to slave validIn
- wren  out  1  to slave wren
- BurstEn  out  1  to slave BurstEn
- Address  out  1  to slave serial Address
- DataIn  out  1  to slave serial DataIn
- ready  in  1  from slave; rising edge = slave accepted beat
- validOut  in  1  from slave; high on first bit of a read byte
- DataOut  in  1  from slave serial read data

## Operation
- States: IDLE, WLOAD, HDR, ADDR, WDATA, WWAIT, RWAIT, RDATA, DONE.
- IDLE: on accept, latch wren/burst/addr; beat counter = BURST_LEN or 1; write -> WLOAD, read -> HDR.
- WLOAD: wdata_ready=1; on wdata_valid latch byte into shift register -> HDR. Stalls indefinitely; validIn stays 0 while stalled.
- HDR (1 cycle): validIn=1, wren/BurstEn driven. First beat -> ADDR; later burst write beats -> WDATA (no address).
- ADDR (ADDR_W cycles): validIn=1, Address=addr[i], i=0..ADDR_W-1. Write -> WDATA; read -> RWAIT with validIn=0.
- WDATA (DATA_W cycles): validIn=1, DataIn=byte[i]. Then validIn=0 -> WWAIT.
- WWAIT: wait rising edge of ready (registered previous value); decrement beats; beats left -> WLOAD, else DONE.
- RWAIT: wait validOut=1; that cycle samples bit 0 -> RDATA.
- RDATA: sample remaining DATA_W-1 bits on consecutive cycles; pulse rdata_valid with the byte; decrement beats; beats left -> RWAIT, else DONE.
- DONE: done=1 one cycle -> IDLE.
- wren, BurstEn held constant from HDR through DONE; Address and DataIn are 0 outside their shift windows.
- Counters: bit counter 4 bits; beat counter $clog2(BURST_LEN)+1 bits; no wrap-around; address is never incremented by this block (slave auto-increments in burst).

## Timing
- Reset values: all outputs 0, rdata=0, state IDLE. Reset mid-transaction drops validIn immediately (asynchronous); no done pulse.
- Single write: accept edge e0, byte latched e1 (if wdata_valid), validIn high for 1+ADDR_W+DATA_W=21 cycles, then low until ready edge; done 1 cycle after ready edge is detected.
- Burst write beat n>1: validIn high for 1+DATA_W=9 cycles per beat.
- Read: validIn high 13 cycles; rdata_valid pulses DATA_W-1 cycles after the validOut cycle.
- ready already high at WWAIT entry is not an edge; a low-to-high transition is required.
- validOut seen outside RWAIT is ignored.

## Configuration
- MASTER_PORT_TIMEOUT_EN defined: cycle counter runs in WWAIT/RWAIT, cleared on state entry; at TIMEOUT cycles pulse err, all bus outputs 0, return to IDLE without done.
- Undefined: no counter, err tied 0, waits are unbounded.

## Test plan
- Single write addr=0x123 data=0xA5 -> Address serial 1,1,0,0,0,1,0,0,1,0,0,0; DataIn 1,0,1,0,0,1,0,1; validIn high 21 cycles; done 1 cycle after ready rises.
- Burst write, 128 random bytes, ready pulsed per beat -> 128 beats, beats 2..128 with 9-cycle validIn, bytes match in order, single done.
- Single read addr=0x0FF, slave returns 0x3C -> rdata=0x3C with one rdata_valid, done next cycle.
- wdata_valid withheld 5 cycles in WLOAD -> validIn stays 0, then transaction proceeds normally.
- Reset asserted mid-ADDR -> all outputs 0 immediately, req_ready=1 after release, next request completes.
- With MASTER_PORT_TIMEOUT_EN, ready never rises -> err pulse exactly TIMEOUT cycles after WWAIT entry, no done.

Source files
------------

// File: rtl/master_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : master_port_if
//  Description : Bundles the request/write-data/read-data handshakes and the
//                serial slave bus used by master_port.
//                master modport = master_port side, slave modport = the
//                environment (request source + serial slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface master_port_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic              req_burst;
    logic [ADDR_W-1:0] req_addr;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;
    logic              validIn;
    logic              wren;
    logic              BurstEn;
    logic              Address;
    logic              DataIn;
    logic              ready;
    logic              validOut;
    logic              DataOut;

    modport master (
        input  req_valid, req_wren, req_burst, req_addr, wdata_valid, wdata,
               ready, validOut, DataOut,
        output req_ready, wdata_ready, rdata_valid, rdata, done, err,
               validIn, wren, BurstEn, Address, DataIn
    );

    modport slave (
        output req_valid, req_wren, req_burst, req_addr, wdata_valid, wdata,
               ready, validOut, DataOut,
        input  req_ready, wdata_ready, rdata_valid, rdata, done, err,
               validIn, wren, BurstEn, Address, DataIn
    );
endinterface
`default_nettype wire

// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
//  Module      : master_port
//  Description : Serializes parallel single/burst read and write requests onto
//                the serial slave bus (header, LSB-first address, LSB-first
//                data beats) and deserializes returned read bytes.
//                Optional watchdog on the bus waits: MASTER_PORT_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module master_port #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 128,
    parameter int TIMEOUT   = 1024
) (
    input  wire logic     clk,
    input  wire logic     reset,
    master_port_if.master bus
);

    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int AIDX_W = $clog2(ADDR_W);
    localparam int DIDX_W = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WLOAD = 4'd1,
        S_HDR   = 4'd2,
        S_ADDR  = 4'd3,
        S_WDATA = 4'd4,
        S_WWAIT = 4'd5,
        S_RWAIT = 4'd6,
        S_RDATA = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic                wren_q, wren_d;
    logic                burst_q, burst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wsh_q, wsh_d;
    // Read bits received so far; the final bit is merged straight from DataOut.
    logic [DATA_W-2:0]   rsh_q, rsh_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [3:0]          bit_q, bit_d;
    logic [BEAT_W-1:0]   beats_q, beats_d;
    // Set until the address has been sent; later burst write beats skip it.
    logic                first_q, first_d;
    logic                ready_prev_q;

    logic                w_ready_rise;
    logic                w_validIn;
    logic                w_Address;
    logic                w_DataIn;
    logic                w_wdata_ready;
    logic                w_rdata_valid;
    logic                w_done;
    logic                w_hold_hdr;
    logic [DATA_W-1:0]   w_rbyte;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                err_q, err_d;
`endif

    assign w_ready_rise = bus.ready & ~ready_prev_q;
    assign w_rbyte      = {bus.DataOut, rsh_q};

    // Next-state and Moore/handshake output decode.
    always_comb begin
        state_d       = state_q;
        wren_d        = wren_q;
        burst_d       = burst_q;
        addr_d        = addr_q;
        wsh_d         = wsh_q;
        rsh_d         = rsh_q;
        rdata_d       = rdata_q;
        bit_d         = bit_q;
        beats_d       = beats_q;
        first_d       = first_q;
        w_validIn     = 1'b0;
        w_Address     = 1'b0;
        w_DataIn      = 1'b0;
        w_wdata_ready = 1'b0;
        w_rdata_valid = 1'b0;
        w_done        = 1'b0;
`ifdef MASTER_PORT_TIMEOUT_EN
        tmr_d         = tmr_q + TMR_W'(1);
        err_d         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wren_d  = bus.req_wren;
                    burst_d = bus.req_burst;
                    addr_d  = bus.req_addr;
                    beats_d = bus.req_burst ? BEAT_W'(BURST_LEN) : BEAT_W'(1);
                    first_d = 1'b1;
                    state_d = bus.req_wren ? S_WLOAD : S_HDR;
                end
            end
            S_WLOAD: begin
                w_wdata_ready = 1'b1;
                if (bus.wdata_valid) begin
                    wsh_d   = bus.wdata;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                w_validIn = 1'b1;
                bit_d     = 4'd0;
                state_d   = first_q ? S_ADDR : S_WDATA;
            end
            S_ADDR: begin
                w_validIn = 1'b1;
                w_Address = addr_q[bit_q[AIDX_W-1:0]];
                if (bit_q == 4'(ADDR_W - 1)) begin
                    bit_d   = 4'd0;
                    first_d = 1'b0;
                    state_d = wren_q ? S_WDATA : S_RWAIT;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_WDATA: begin
                w_validIn = 1'b1;
                w_DataIn  = wsh_q[bit_q[DIDX_W-1:0]];
                if (bit_q == 4'(DATA_W - 1)) begin
                    state_d = S_WWAIT;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_WWAIT: begin
                if (w_ready_rise) begin
                    beats_d = beats_q - BEAT_W'(1);
                    state_d = (beats_q == BEAT_W'(1)) ? S_DONE : S_WLOAD;
                end
`ifdef MASTER_PORT_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_RWAIT: begin
                if (bus.validOut) begin
                    rsh_d   = {bus.DataOut, rsh_q[DATA_W-2:1]};
                    bit_d   = 4'd1;
                    state_d = S_RDATA;
                end
`ifdef MASTER_PORT_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_RDATA: begin
                rsh_d = {bus.DataOut, rsh_q[DATA_W-2:1]};
                if (bit_q == 4'(DATA_W - 1)) begin
                    w_rdata_valid = 1'b1;
                    rdata_d       = w_rbyte;
                    beats_d       = beats_q - BEAT_W'(1);
                    state_d       = (beats_q == BEAT_W'(1)) ? S_DONE : S_RWAIT;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end
            S_DONE: begin
                w_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef MASTER_PORT_TIMEOUT_EN
        // The watchdog restarts whenever a new state is entered.
        if (state_d != state_q) begin
            tmr_d = '0;
        end
`endif
    end

    // wren/BurstEn stay valid from the first header until the transaction ends,
    // including the WLOAD gaps between burst write beats.
    assign w_hold_hdr = (state_q != S_IDLE) && !((state_q == S_WLOAD) && first_q);

    assign bus.req_ready   = (state_q == S_IDLE) && !reset;
    assign bus.wdata_ready = w_wdata_ready;
    assign bus.validIn     = w_validIn;
    assign bus.Address     = w_Address;
    assign bus.DataIn      = w_DataIn;
    assign bus.wren        = w_hold_hdr & wren_q;
    assign bus.BurstEn     = w_hold_hdr & burst_q;
    assign bus.rdata_valid = w_rdata_valid;
    assign bus.rdata       = w_rdata_valid ? w_rbyte : rdata_q;
    assign bus.done        = w_done;

    // Main state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wren_q       <= 1'b0;
            burst_q      <= 1'b0;
            addr_q       <= '0;
            wsh_q        <= '0;
            rsh_q        <= '0;
            rdata_q      <= '0;
            bit_q        <= 4'd0;
            beats_q      <= '0;
            first_q      <= 1'b0;
            ready_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wren_q       <= wren_d;
            burst_q      <= burst_d;
            addr_q       <= addr_d;
            wsh_q        <= wsh_d;
            rsh_q        <= rsh_d;
            rdata_q      <= rdata_d;
            bit_q        <= bit_d;
            beats_q      <= beats_d;
            first_q      <= first_d;
            ready_prev_q <= bus.ready;
        end
    end

`ifdef MASTER_PORT_TIMEOUT_EN
    // Watchdog counter and registered abort pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    // TIMEOUT has no function without the watchdog.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
    assign bus.err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_master_port
//  Description : Randomized scoreboard bench for master_port. Issued requests
//                push expected serial frames; a bus monitor decodes frames and
//                read/done pulses and compares them against the queues; a
//                behavioural slave answers with ready edges and read bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_master_port;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 128;
    localparam int TIMEOUT   = 1024;

    logic clk = 1'b0;
    logic reset;

    master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    master_port #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          len;
        logic [11:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic        burst;
        logic        last;
        int          beats;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        int         when;
    } rd_t;

    frame_t exp_frame_q[$];
    frame_t resp_q[$];
    rd_t    exp_rd_q[$];
    int     exp_done_q[$];
    int     n_done      = 0;
    int     n_err       = 0;
    int     wwait_entry = 0;
    bit     no_ready    = 0;
    int     rd_fixed    = -1;

    // ---------------- bus monitor ----------------
    logic [0:31] a_bits, d_bits;
    int          idx = 0;
    logic        cur_wr, cur_burst;
    frame_t      mf;
    rd_t         mr;
    logic [11:0] got_a;
    logic [7:0]  got_d;
    int          base;

    always @(negedge clk) begin
        if (reset) begin
            idx = 0;
        end else begin
            if (bus.validIn) begin
                if (idx < 32) begin
                    a_bits[idx] = bus.Address;
                    d_bits[idx] = bus.DataIn;
                end
                if (idx == 0) begin
                    cur_wr    = bus.wren;
                    cur_burst = bus.BurstEn;
                end
                idx++;
            end else begin
                chk("idle_lines", {30'd0, bus.Address, bus.DataIn}, 32'd0);
                if (idx > 0) begin
                    if (exp_frame_q.size() == 0) begin
                        chk("frame_q_size", exp_frame_q.size(), 1);
                    end else begin
                        mf = exp_frame_q.pop_front();
                        chk("frame_len", idx, mf.len);
                        chk("hdr_wren", cur_wr, mf.wr);
                        chk("hdr_burst", cur_burst, mf.burst);
                        chk("hdr_lines", {30'd0, a_bits[0], d_bits[0]}, 32'd0);
                        if (mf.len != 9 && idx >= 13) begin
                            for (int i = 0; i < 12; i++) got_a[i] = a_bits[1+i];
                            chk("addr_bits", got_a, mf.addr);
                            chk("datain_in_addr", d_bits[1:12], 12'd0);
                        end
                        if (mf.wr) begin
                            base = (mf.len == 9) ? 1 : 13;
                            if (idx >= base + 8) begin
                                for (int i = 0; i < 8; i++) got_d[i] = d_bits[base+i];
                                chk("data_bits", got_d, mf.data);
                                chk("addr_in_data", a_bits[base +: 8], 8'd0);
                            end
                        end
                        resp_q.push_back(mf);
                        wwait_entry = cyc;
                    end
                    idx = 0;
                end
            end
            if (bus.wdata_ready && !bus.wdata_valid)
                chk("stall_validIn", bus.validIn, 0);
            if (bus.done) begin
                n_done++;
                if (exp_done_q.size() == 0) chk("done_q_size", exp_done_q.size(), 1);
                else chk("done_cycle", cyc, exp_done_q.pop_front());
            end
            if (bus.rdata_valid) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rd_q_size", exp_rd_q.size(), 1);
                end else begin
                    mr = exp_rd_q.pop_front();
                    chk("rdata", bus.rdata, mr.data);
                    chk("rdata_cycle", cyc, mr.when);
                end
            end
`ifdef MASTER_PORT_TIMEOUT_EN
            if (bus.err) begin
                n_err++;
                chk("err_cycle", cyc, wwait_entry + TIMEOUT);
            end
`else
            chk("err_low", bus.err, 0);
`endif
        end
    end

    // ---------------- behavioural serial slave ----------------
    frame_t     rf;
    logic [7:0] rbyte;
    initial begin
        bus.ready    = 1'b0;
        bus.validOut = 1'b0;
        bus.DataOut  = 1'b0;
        forever begin
            tick();
            if (resp_q.size() > 0 && !reset) begin
                rf = resp_q.pop_front();
                if (rf.wr) begin
                    if (!no_ready) begin
                        if (bus.ready) begin
                            bus.ready = 1'b0;
                            tick();
                        end
                        // Spurious validOut during the write wait must be ignored.
                        repeat ($urandom_range(0, 4)) begin
                            bus.validOut = 1'($urandom_range(0, 1));
                            bus.DataOut  = 1'($urandom_range(0, 1));
                            tick();
                        end
                        bus.validOut = 1'b0;
                        bus.DataOut  = 1'b0;
                        bus.ready    = 1'b1;
                        if (rf.last) exp_done_q.push_back(cyc + 1);
                        tick();
                        bus.ready = 1'b0;
                    end
                end else begin
                    for (int b = 0; b < rf.beats; b++) begin
                        repeat ($urandom_range(0, 3)) tick();
                        rbyte = (rd_fixed >= 0) ? 8'(rd_fixed) : 8'($urandom);
                        exp_rd_q.push_back('{data: rbyte, when: cyc + 7});
                        if (b == rf.beats - 1) exp_done_q.push_back(cyc + 8);
                        for (int i = 0; i < 8; i++) begin
                            bus.validOut = (i == 0);
                            bus.DataOut  = rbyte[i];
                            tick();
                        end
                        bus.validOut = 1'b0;
                        bus.DataOut  = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- request driver ----------------
    task automatic do_txn(input bit wr, input bit burst, input logic [11:0] addr,
                          input int fixed, input int stall, input bit exp_done);
        int         n0    = n_done;
        int         beats = burst ? BURST_LEN : 1;
        int         t;
        logic [7:0] b;
        if (!wr)
            exp_frame_q.push_back('{len: 13, addr: addr, data: 8'h00, wr: 1'b0,
                                    burst: burst, last: 1'b1, beats: beats});
        bus.req_valid = 1'b1;
        bus.req_wren  = wr;
        bus.req_burst = burst;
        bus.req_addr  = addr;
        t = 0;
        while (!bus.req_ready && t < 100) begin tick(); t++; end
        tick();
        bus.req_valid = 1'b0;
        chk("req_ready_busy", bus.req_ready, 0);
        if (wr) begin
            for (int i = 0; i < beats; i++) begin
                b = (fixed >= 0) ? 8'(fixed) : 8'($urandom);
                exp_frame_q.push_back('{len: (i == 0) ? 21 : 9, addr: addr, data: b,
                                        wr: 1'b1, burst: burst,
                                        last: (i == beats - 1), beats: beats});
                t = 0;
                while (!bus.wdata_ready && t < 2000) begin tick(); t++; end
                if (!bus.wdata_ready) begin
                    chk("wdata_ready_wait", bus.wdata_ready, 1);
                    break;
                end
                repeat ((i == 0) ? stall : $urandom_range(0, 2)) tick();
                bus.wdata_valid = 1'b1;
                bus.wdata       = b;
                tick();
                bus.wdata_valid = 1'b0;
            end
        end
        if (exp_done) begin
            t = 0;
            while (n_done == n0 && t < 20000) begin tick(); t++; end
            chk("txn_done", n_done, n0 + 1);
        end
    endtask

    int n0;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_wren    = 1'b0;
        bus.req_burst   = 1'b0;
        bus.req_addr    = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        tick();
        tick();
        chk("reset_outputs", {22'd0, bus.validIn, bus.wren, bus.BurstEn, bus.Address,
                              bus.DataIn, bus.req_ready, bus.wdata_ready,
                              bus.rdata_valid, bus.done, bus.err}, 32'd0);
        chk("reset_rdata", bus.rdata, 0);
        reset = 1'b0;
        tick();
        chk("req_ready_idle", bus.req_ready, 1);

        // Directed single write with ready already high before the wait.
        bus.ready = 1'b1;
        do_txn(1'b1, 1'b0, 12'h123, 8'hA5, 0, 1'b1);
        // Write with wdata withheld for 5 cycles.
        do_txn(1'b1, 1'b0, 12'h5A7, -1, 5, 1'b1);
        // Directed single read.
        rd_fixed = 8'h3C;
        do_txn(1'b0, 1'b0, 12'h0FF, -1, 0, 1'b1);
        chk("rdata_held", bus.rdata, 8'h3C);
        rd_fixed = -1;
        // Burst write of random bytes.
        do_txn(1'b1, 1'b1, 12'($urandom), -1, 0, 1'b1);
        // Random mix.
        for (int k = 0; k < 10; k++)
            do_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                   12'($urandom), -1, $urandom_range(0, 3), 1'b1);
        // Burst read.
        do_txn(1'b0, 1'b1, 12'($urandom), -1, 0, 1'b1);

        // Reset in the middle of the address phase.
        n0            = n_done;
        bus.req_valid = 1'b1;
        bus.req_wren  = 1'b1;
        bus.req_burst = 1'b0;
        bus.req_addr  = 12'hABC;
        tick();
        bus.req_valid   = 1'b0;
        bus.wdata_valid = 1'b1;
        bus.wdata       = 8'h77;
        tick();
        bus.wdata_valid = 1'b0;
        repeat (4) tick();
        chk("pre_reset_validIn", bus.validIn, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {23'd0, bus.validIn, bus.wren, bus.BurstEn,
                                    bus.Address, bus.DataIn, bus.wdata_ready,
                                    bus.rdata_valid, bus.done, bus.err}, 32'd0);
        exp_frame_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("req_ready_after_reset", bus.req_ready, 1);
        chk("no_done_on_reset", n_done, n0);
        do_txn(1'b1, 1'b0, 12'h321, -1, 1, 1'b1);

`ifdef MASTER_PORT_TIMEOUT_EN
        // Slave never raises ready: watchdog abort without done.
        no_ready = 1;
        n0       = n_done;
        do_txn(1'b1, 1'b0, 12'h44F, -1, 0, 1'b0);
        for (int t = 0; t < TIMEOUT + 100 && n_err == 0; t++) tick();
        chk("err_seen", n_err, 1);
        chk("no_done_on_err", n_done, n0);
        no_ready = 0;
        repeat (3) tick();
        do_txn(1'b0, 1'b0, 12'h010, -1, 0, 1'b1);
`endif

        repeat (5) tick();
        chk("leftover_frames", exp_frame_q.size(), 0);
        chk("leftover_done", exp_done_q.size(), 0);
        chk("leftover_rdata", exp_rd_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
